// File: rtl/plab2_proc_muldiv_iter_if.sv
// Request/response bundle between the D/X stages and the iterative
// multiply/divide unit.
//
// Signals:
//   domain      security domain of the requesting instruction
//   in_val      request valid (D stage -> unit)
//   in_rdy      request ready (unit -> D stage)
//   in_func     0=MUL 1=DIV 2=DIVU 3=REM 4=REMU, 5-7 reserved
//   in_a        multiplicand / dividend
//   in_b        multiplier / divisor
//   kill        abort the in-flight operation (pipeline flush)
//   out_val     response valid (unit -> X stage)
//   out_rdy     response ready (X stage -> unit)
//   out_result  result word
//   out_domain  domain captured when the request was accepted
//   busy        unit is not idle
//
// Modports: master = requester/consumer side, slave = the unit itself.
interface plab2_proc_muldiv_iter_if #(
  parameter int p_nbits = 32
);
  logic               domain;
  logic               in_val;
  logic               in_rdy;
  logic [2:0]         in_func;
  logic [p_nbits-1:0] in_a;
  logic [p_nbits-1:0] in_b;
  logic               kill;
  logic               out_val;
  logic               out_rdy;
  logic [p_nbits-1:0] out_result;
  logic               out_domain;
  logic               busy;

  modport master (
    output domain, in_val, in_func, in_a, in_b, kill, out_rdy,
    input  in_rdy, out_val, out_result, out_domain, busy
  );

  modport slave (
    input  domain, in_val, in_func, in_a, in_b, kill, out_rdy,
    output in_rdy, out_val, out_result, out_domain, busy
  );
endinterface

// File: rtl/plab2_proc_muldiv_iter.sv
// Iterative multiply/divide unit for the X stage.
//
// MUL uses shift-add on the raw operands (low p_nbits of the product), with
// optional early termination once the remaining multiplier bits are zero.
// DIV/DIVU/REM/REMU use restoring division on magnitudes, one quotient bit
// per cycle for exactly p_nbits cycles, with a sign fixup on completion.
// The security-domain label is captured at accept and returned with the
// result. kill drops the in-flight operation without a response.
//
// Ports:
//   clk    clock
//   reset  synchronous active-high reset
//   bus    request/response bundle (slave modport), see the interface file
module plab2_proc_muldiv_iter #(
  parameter int p_nbits      = 32,
  parameter bit p_early_term = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  plab2_proc_muldiv_iter_if.slave      bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] F_MUL  = 3'd0;
  localparam logic [2:0] F_DIV  = 3'd1;
  localparam logic [2:0] F_DIVU = 3'd2;
  localparam logic [2:0] F_REM  = 3'd3;
  localparam logic [2:0] F_REMU = 3'd4;

  localparam int CW = $clog2(p_nbits) + 1;

  logic [1:0]         state_q,   state_d;
  logic [2:0]         func_q,    func_d;
  logic               domain_q,  domain_d;
  logic [p_nbits-1:0] a_q,       a_d;
  logic [p_nbits-1:0] b_q,       b_d;
  logic [p_nbits-1:0] acc_q,     acc_d;
  logic [p_nbits:0]   rem_q,     rem_d;
  logic [CW-1:0]      cnt_q,     cnt_d;
  logic               negQuot_q, negQuot_d;
  logic               negRem_q,  negRem_d;
  logic               divZero_q, divZero_d;
  logic [p_nbits-1:0] result_q,  result_d;

  // Operand conditioning at accept: signed divide ops work on magnitudes.
  logic               signedOp;
  logic               aNeg;
  logic               bNeg;
  logic [p_nbits-1:0] aAbs;
  logic [p_nbits-1:0] bAbs;

  assign signedOp = (bus.in_func == F_DIV) || (bus.in_func == F_REM);
  assign aNeg     = signedOp && bus.in_a[p_nbits-1];
  assign bNeg     = signedOp && bus.in_b[p_nbits-1];
  assign aAbs     = aNeg ? (~bus.in_a + 1'b1) : bus.in_a;
  assign bAbs     = bNeg ? (~bus.in_b + 1'b1) : bus.in_b;

  // One restoring-division step. a_q doubles as the dividend shift register
  // and the quotient collector: dividend bits leave at the top while
  // quotient bits enter at the bottom. The partial remainder never exceeds
  // 2*divisor-1, so the top bit of the difference is a reliable borrow.
  logic [p_nbits:0]   remShift;
  logic [p_nbits:0]   remDiff;
  logic               qBit;
  logic [p_nbits:0]   remStep;
  logic [p_nbits-1:0] quoStep;
  logic [p_nbits-1:0] remLow;

  assign remShift = {rem_q[p_nbits-1:0], a_q[p_nbits-1]};
  assign remDiff  = remShift - {1'b0, b_q};
  assign qBit     = ~remDiff[p_nbits];
  assign remStep  = qBit ? remDiff : remShift;
  assign quoStep  = {a_q[p_nbits-2:0], qBit};
  assign remLow   = remStep[p_nbits-1:0];

  // One shift-add multiply step.
  logic [p_nbits-1:0] mulAcc;
  logic               lastIter;

  assign mulAcc   = acc_q + (b_q[0] ? a_q : '0);
  assign lastIter = (cnt_q == CW'(p_nbits - 1));

  // Next-state logic. Accept happens in IDLE whenever in_val is high; the
  // register block gives reset priority, which is what keeps in_rdy honest
  // while reset is asserted. kill is only looked at outside IDLE, so it
  // never blocks an accept, and it beats an out_rdy handshake in DONE.
  always_comb begin
    state_d   = state_q;
    func_d    = func_q;
    domain_d  = domain_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    negQuot_d = negQuot_q;
    negRem_d  = negRem_q;
    divZero_d = divZero_q;
    result_d  = result_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_val) begin
          func_d    = bus.in_func;
          domain_d  = bus.domain;
          a_d       = aAbs;
          b_d       = bAbs;
          acc_d     = '0;
          rem_d     = '0;
          cnt_d     = '0;
          negQuot_d = aNeg ^ bNeg;
          negRem_d  = aNeg;
          divZero_d = (bus.in_b == '0);
          state_d   = S_CALC;
        end
      end

      S_CALC: begin
        if (bus.kill) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          case (func_q)
            F_MUL: begin
              acc_d = mulAcc;
              a_d   = a_q << 1;
              b_d   = b_q >> 1;
              if (p_early_term ? (b_q[p_nbits-1:1] == '0) : lastIter) begin
                result_d = mulAcc;
                state_d  = S_DONE;
              end
            end
            F_DIV, F_DIVU, F_REM, F_REMU: begin
              a_d   = quoStep;
              rem_d = remStep;
              if (lastIter) begin
                // Divide-by-zero keeps the all-ones quotient unnegated; its
                // remainder is |a| with a's sign, i.e. a itself.
                if (func_q == F_DIV && negQuot_q && !divZero_q) begin
                  result_d = ~quoStep + 1'b1;
                end else if (func_q == F_DIV || func_q == F_DIVU) begin
                  result_d = quoStep;
                end else if (func_q == F_REM && negRem_q) begin
                  result_d = ~remLow + 1'b1;
                end else begin
                  result_d = remLow;
                end
                state_d = S_DONE;
              end
            end
            default: begin
              result_d = '0;
              state_d  = S_DONE;
            end
          endcase
        end
      end

      S_DONE: begin
        if (bus.kill || bus.out_rdy) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers, synchronously cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      func_q    <= '0;
      domain_q  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      negQuot_q <= 1'b0;
      negRem_q  <= 1'b0;
      divZero_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      func_q    <= func_d;
      domain_q  <= domain_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      negQuot_q <= negQuot_d;
      negRem_q  <= negRem_d;
      divZero_q <= divZero_d;
      result_q  <= result_d;
    end
  end

  assign bus.in_rdy     = (state_q == S_IDLE) && !reset;
  assign bus.out_val    = (state_q == S_DONE);
  assign bus.out_result = result_q;
  assign bus.out_domain = domain_q;
  assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_plab2_proc_muldiv_iter.sv
// Directed bench for the iterative multiply/divide unit (32-bit, early
// terminating multiply). Each vector is issued, its latency counted in
// clock edges after the accept edge, and the result/domain compared with
// hand-computed values.
module tb_plab2_proc_muldiv_iter;

  logic clk;
  logic reset;
  int   vectorCount;
  int   miscompareCount;

  plab2_proc_muldiv_iter_if #(.p_nbits(32)) bus ();

  plab2_proc_muldiv_iter #(
    .p_nbits      (32),
    .p_early_term (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      miscompareCount++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Issue one operation, scramble the inputs after accept, count the edges
  // until out_val, check result/domain, optionally stall the response, then
  // complete the handshake and check the unit is ready again.
  task automatic applyStimulus(input string tag, input logic [2:0] func,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic dom, input logic [31:0] expResult,
                               input int expK, input int holdCycles,
                               input logic killAtAccept);
    int cycles;
    @(negedge clk);
    bus.in_val  = 1'b1;
    bus.in_func = func;
    bus.in_a    = a;
    bus.in_b    = b;
    bus.domain  = dom;
    bus.kill    = killAtAccept;
    bus.out_rdy = 1'b0;
    checkOutput({tag, "/in_rdy"}, 32'(bus.in_rdy), 32'd1);
    @(posedge clk);
    #1;
    bus.in_val  = 1'b0;
    bus.kill    = 1'b0;
    bus.domain  = ~dom;
    bus.in_a    = ~a;
    bus.in_b    = ~b;
    bus.in_func = 3'd0;
    cycles = 0;
    do begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end while (!bus.out_val && cycles < 100);
    checkOutput({tag, "/latency"}, 32'(cycles), 32'(expK));
    checkOutput({tag, "/result"}, bus.out_result, expResult);
    checkOutput({tag, "/domain"}, 32'(bus.out_domain), 32'(dom));
    for (int i = 0; i < holdCycles; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput({tag, "/hold_val"}, 32'(bus.out_val), 32'd1);
      checkOutput({tag, "/hold_result"}, bus.out_result, expResult);
      checkOutput({tag, "/hold_in_rdy"}, 32'(bus.in_rdy), 32'd0);
    end
    bus.out_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_rdy = 1'b0;
    checkOutput({tag, "/post_val"}, 32'(bus.out_val), 32'd0);
    checkOutput({tag, "/post_in_rdy"}, 32'(bus.in_rdy), 32'd1);
  endtask

  // Top-level sequence: reset, directed vectors, backpressure, kill, reset.
  initial begin
    int outSeen;
    vectorCount     = 0;
    miscompareCount = 0;
    reset       = 1'b1;
    bus.in_val  = 1'b0;
    bus.in_func = 3'd0;
    bus.in_a    = '0;
    bus.in_b    = '0;
    bus.domain  = 1'b0;
    bus.kill    = 1'b0;
    bus.out_rdy = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset/in_rdy", 32'(bus.in_rdy), 32'd0);
    checkOutput("reset/out_val", 32'(bus.out_val), 32'd0);
    checkOutput("reset/out_result", bus.out_result, 32'd0);
    checkOutput("reset/out_domain", 32'(bus.out_domain), 32'd0);
    checkOutput("reset/busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("reset/in_rdy_after", 32'(bus.in_rdy), 32'd1);

    applyStimulus("mul7x3",     3'd0, 32'd7,        32'd3,        1'b1, 32'd21,       2,  0, 1'b0);
    applyStimulus("mul7xneg3",  3'd0, 32'd7,        32'hFFFFFFFD, 1'b0, 32'hFFFFFFEB, 32, 0, 1'b0);
    applyStimulus("mul7x0",     3'd0, 32'd7,        32'd0,        1'b1, 32'd0,        1,  0, 1'b0);
    applyStimulus("divneg7",    3'd1, 32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFD, 32, 0, 1'b0);
    applyStimulus("remneg7",    3'd3, 32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFF, 32, 0, 1'b0);
    applyStimulus("divu100",    3'd2, 32'd100,      32'd7,        1'b0, 32'd14,       32, 0, 1'b0);
    applyStimulus("remu100",    3'd4, 32'd100,      32'd7,        1'b1, 32'd2,        32, 0, 1'b0);
    applyStimulus("divovf",     3'd1, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h80000000, 32, 0, 1'b0);
    applyStimulus("removf",     3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0,        32, 0, 1'b0);
    applyStimulus("divu5by0",   3'd2, 32'd5,        32'd0,        1'b0, 32'hFFFFFFFF, 32, 0, 1'b0);
    applyStimulus("remu5by0",   3'd4, 32'd5,        32'd0,        1'b1, 32'd5,        32, 0, 1'b0);
    applyStimulus("divneg5by0", 3'd1, 32'hFFFFFFFB, 32'd0,        1'b0, 32'hFFFFFFFF, 32, 0, 1'b0);
    applyStimulus("remneg5by0", 3'd3, 32'hFFFFFFFB, 32'd0,        1'b1, 32'hFFFFFFFB, 32, 0, 1'b0);
    applyStimulus("reserved",   3'd6, 32'd9,        32'd4,        1'b1, 32'd0,        1,  0, 1'b0);
    applyStimulus("backpress",  3'd2, 32'd100,      32'd7,        1'b1, 32'd14,       32, 5, 1'b0);
    applyStimulus("killidle",   3'd0, 32'd6,        32'd5,        1'b0, 32'd30,       3,  0, 1'b1);

    // Kill a DIV in its tenth CALC cycle; no response may appear.
    @(negedge clk);
    bus.in_val  = 1'b1;
    bus.in_func = 3'd1;
    bus.in_a    = 32'd1000;
    bus.in_b    = 32'd3;
    @(posedge clk);
    #1;
    bus.in_val = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    checkOutput("kill/busy_before", 32'(bus.busy), 32'd1);
    bus.kill = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.kill = 1'b0;
    checkOutput("kill/in_rdy", 32'(bus.in_rdy), 32'd1);
    checkOutput("kill/busy", 32'(bus.busy), 32'd0);
    outSeen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.out_val) outSeen++;
    end
    checkOutput("kill/no_response", 32'(outSeen), 32'd0);
    applyStimulus("mulafterkill", 3'd0, 32'd6, 32'd5, 1'b1, 32'd30, 3, 0, 1'b0);

    // Kill in DONE while out_rdy is high: the result is dropped.
    @(negedge clk);
    bus.in_val  = 1'b1;
    bus.in_func = 3'd0;
    bus.in_a    = 32'd3;
    bus.in_b    = 32'd1;
    @(posedge clk);
    #1;
    bus.in_val = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("killdone/out_val", 32'(bus.out_val), 32'd1);
    bus.kill    = 1'b1;
    bus.out_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.kill    = 1'b0;
    bus.out_rdy = 1'b0;
    checkOutput("killdone/val_after", 32'(bus.out_val), 32'd0);
    checkOutput("killdone/in_rdy", 32'(bus.in_rdy), 32'd1);

    // Reset pulse in the middle of a divide.
    @(negedge clk);
    bus.in_val  = 1'b1;
    bus.in_func = 3'd2;
    bus.in_a    = 32'd77;
    bus.in_b    = 32'd5;
    @(posedge clk);
    #1;
    bus.in_val = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midreset/in_rdy_in_reset", 32'(bus.in_rdy), 32'd0);
    checkOutput("midreset/busy", 32'(bus.busy), 32'd0);
    checkOutput("midreset/out_result", bus.out_result, 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("midreset/in_rdy", 32'(bus.in_rdy), 32'd1);
    checkOutput("midreset/out_val", 32'(bus.out_val), 32'd0);
    applyStimulus("mulafterreset", 3'd0, 32'd6, 32'd5, 1'b0, 32'd30, 3, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule
